// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer for the shared memory port: one transaction
// at a time, with a timeout abort when memory never signals ready.
module mem_port_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] addr0,
    input  logic [WIDTH-1:0] addr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    input  logic             we0,
    input  logic             we1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic             mem_en,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] rdata,
    output logic             err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          sel_nxt;
    logic          last_grant;
    logic          grant;
    logic          timed_out;

    // Next-state decode; sel_nxt names the owner of the upcoming BUSY/DONE cycles.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = sel;
        grant     = 1'b0;
        timed_out = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant     = 1'b1;
                    sel_nxt   = (req0 && req1) ? ~last_grant : req1;
                    cnt_nxt   = '0;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    state_nxt = DONE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    timed_out = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // All outputs are flops fed from the next-state decode, so nothing on the
    // output side depends combinationally on an input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            sel        <= 1'b0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            rdata      <= '0;
            err        <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            sel    <= sel_nxt;
            gnt0   <= (state_nxt != IDLE) && !sel_nxt;
            gnt1   <= (state_nxt != IDLE) &&  sel_nxt;
            mem_en <= (state_nxt == BUSY);
            done0  <= (state_nxt == DONE) && !sel_nxt;
            done1  <= (state_nxt == DONE) &&  sel_nxt;
            err    <= timed_out;
            if (grant) begin
                mem_addr  <= sel_nxt ? addr1  : addr0;
                mem_wdata <= sel_nxt ? wdata1 : wdata0;
                mem_we    <= sel_nxt ? we1    : we0;
            end
            if (state == BUSY && mem_ready) begin
                rdata <= mem_rdata;
            end
            // Fairness memory moves only when a transaction actually completes.
            if (state == BUSY && state_nxt == DONE) begin
                last_grant <= sel;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: reset, read, write, round-robin tie,
// timeout abort, stray inputs and asynchronous reset mid-transaction.
module tb_mem_port_arbiter;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0, req1, we0, we1, mem_ready;
    logic [WIDTH-1:0] addr0, addr1, wdata0, wdata1, mem_rdata;
    logic             gnt0, gnt1, sel, mem_en, mem_we, done0, done1, err;
    logic [WIDTH-1:0] mem_addr, mem_wdata, rdata;

    int checks = 0;
    int fails  = 0;
    int en_cycles;

    mem_port_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .we0(we0), .we1(we1),
        .gnt0(gnt0), .gnt1(gnt1), .sel(sel),
        .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .done0(done0), .done1(done1),
        .rdata(rdata), .err(err)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle 1 time unit past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r0, input logic r1, input logic rdy);
        req0      = r0;
        req1      = r1;
        mem_ready = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] obs,
                               input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Packs the 1-bit control outputs: {gnt0,gnt1,sel,mem_en,done0,done1,err}.
    function automatic logic [WIDTH-1:0] ctl();
        return {25'd0, gnt0, gnt1, sel, mem_en, done0, done1, err};
    endfunction

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        we0 = 1'b0; we1 = 1'b0; mem_rdata = '0;
        tick();
        tick();
        checkOutput("reset_ctl", ctl(), 32'h0);
        checkOutput("reset_addr", mem_addr, 32'h0);
        checkOutput("reset_rdata", rdata, 32'h0);
        rst = 1'b0;
        tick();

        // Single read from requester 0, ready on the second BUSY cycle.
        addr0 = 32'h0000_0040; wdata0 = 32'h0; we0 = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("read_busy_ctl", ctl(), 32'b1001000);
        checkOutput("read_addr", mem_addr, 32'h40);
        checkOutput("read_we", {31'd0, mem_we}, 32'd0);
        tick();
        checkOutput("read_busy2_ctl", ctl(), 32'b1001000);
        mem_rdata = 32'hDEAD_BEEF;
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("read_done_ctl", ctl(), 32'b1000100);
        checkOutput("read_rdata", rdata, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("read_idle_ctl", ctl(), 32'b0000000);

        // Write from requester 1.
        addr1 = 32'h100; wdata1 = 32'h1234_5678; we1 = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("write_busy_ctl", ctl(), 32'b0111000);
        checkOutput("write_addr", mem_addr, 32'h100);
        checkOutput("write_wdata", mem_wdata, 32'h1234_5678);
        checkOutput("write_we", {31'd0, mem_we}, 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("write_done_ctl", ctl(), 32'b0110010);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("write_idle_sel_held", ctl(), 32'b0010000);

        // Both requesters held high with instant ready: strict alternation, a done every 3 cycles.
        we1 = 1'b0;
        mem_rdata = 32'hCAFE_0001;
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int t = 0; t < 4; t++) begin
            tick();
            checkOutput($sformatf("tie%0d_busy", t), ctl(),
                        (t % 2 == 0) ? 32'b1001000 : 32'b0111000);
            checkOutput($sformatf("tie%0d_addr", t), mem_addr,
                        (t % 2 == 0) ? 32'h40 : 32'h100);
            tick();
            checkOutput($sformatf("tie%0d_done", t), ctl(),
                        (t % 2 == 0) ? 32'b1000100 : 32'b0110010);
            if (t == 3) applyStimulus(1'b0, 1'b0, 1'b0);
            tick();
            checkOutput($sformatf("tie%0d_idle", t), {31'd0, mem_en}, 32'd0);
        end
        checkOutput("tie_rdata", rdata, 32'hCAFE_0001);

        // Timeout: memory never answers.
        mem_rdata = 32'h5555_5555;
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        en_cycles = 0;
        while (mem_en && en_cycles < 40) begin
            en_cycles++;
            tick();
        end
        checkOutput("timeout_en_cycles", en_cycles, TIMEOUT);
        checkOutput("timeout_done_ctl", ctl(), 32'b1000101);
        checkOutput("timeout_rdata", rdata, 32'hCAFE_0001);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("timeout_idle_ctl", ctl(), 32'b0000000);

        // Normal transaction after the abort.
        mem_rdata = 32'h0BAD_F00D;
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("post_to_busy", ctl(), 32'b1001000);
        tick();
        checkOutput("post_to_done", ctl(), 32'b1000100);
        checkOutput("post_to_rdata", rdata, 32'h0BAD_F00D);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();

        // Stray mem_ready in IDLE, then address/request changes during BUSY.
        mem_rdata = 32'h0000_0BAD;
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("stray_ready_ctl", ctl(), 32'b0000000);
        checkOutput("stray_ready_rdata", rdata, 32'h0BAD_F00D);
        addr0 = 32'h80;
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("stray_busy_addr", mem_addr, 32'h80);
        addr0 = 32'h999;
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("stray_addr_held", mem_addr, 32'h80);
        checkOutput("stray_drop_ctl", ctl(), 32'b1001000);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("stray_done_ctl", ctl(), 32'b1000100);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();

        // Asynchronous reset in the middle of a requester-1 transaction.
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("arst_pre_ctl", ctl(), 32'b0111000);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_ctl", ctl(), 32'b0000000);
        checkOutput("arst_addr", mem_addr, 32'h0);
        checkOutput("arst_rdata", rdata, 32'h0);
        #1 rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("arst_tie_first", ctl(), 32'b1001000);
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick();
        checkOutput("arst_tie_done", ctl(), 32'b1000100);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
